mq_byte_out: RTL and testbench

MQ coder byte-output stage, directly downstream of the CU register stage. Consumes the registered carry/renormalisation/shift bundle and maintains the pending byte B. It applies carry propagation and emits finished code bytes through a small FIFO onto a valid/ready byte stream. It also handles the flush tail and detects marker-stuffing violations.

---
 rtl/mq_pkg.sv | 16 +
 rtl/mq_byte_out_if.sv | 28 ++
 rtl/mq_bo_fifo.sv | 40 ++++
 rtl/mq_byte_out.sv | 155 +++++++++++++++
 tb/tb_mq_byte_out.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mq_pkg.sv
// Shared constants and helpers for the MQ coder byte-output stage.
package mq_pkg;
  localparam logic [7:0]  MARKER       = 8'hFF;
  localparam int unsigned SliceW       = 22;
  localparam int unsigned ByteMsb      = 21;
  localparam int unsigned ByteLsb      = 14;
  localparam int unsigned ByteW        = ByteMsb - ByteLsb + 1;
  localparam int unsigned DefFifoDepth = 4;
  localparam int unsigned DefCntW      = 16;

  // New byte N carried by byte event k of the shift bundle.
  function automatic logic [ByteW-1:0] slice_byte(input logic [2*SliceW-1:0] v,
                                                  input int unsigned k);
    return v[k*SliceW + ByteLsb +: ByteW];
  endfunction
endpackage

// File: rtl/mq_byte_out_if.sv
// Upstream bundle plus downstream byte stream of the MQ byte-output stage.
interface mq_byte_out_if import mq_pkg::*; #(
  parameter int unsigned CNT_W = DefCntW
) ();
  logic [1:0]            Carry;
  logic [1:0]            Renor;
  logic [2*SliceW-1:0]   CShift8CT;
  logic                  AddB;
  logic                  rst_BO;
  logic                  flush_BO;
  logic                  in_ready;
  logic [7:0]            byte_data;
  logic                  byte_valid;
  logic                  byte_ready;
  logic [CNT_W-1:0]      byte_count;
  logic                  flush_done;
  logic                  err;

  modport master (
    output Carry, Renor, CShift8CT, AddB, rst_BO, flush_BO, byte_ready,
    input  in_ready, byte_data, byte_valid, byte_count, flush_done, err
  );

  modport slave (
    input  Carry, Renor, CShift8CT, AddB, rst_BO, flush_BO, byte_ready,
    output in_ready, byte_data, byte_valid, byte_count, flush_done, err
  );
endinterface

// File: rtl/mq_bo_fifo.sv
// Show-ahead FIFO accepting up to two writes (event order) and one read per cycle.
module mq_bo_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 wr_cnt,
  input  logic [Width-1:0]           wr_data0,
  input  logic [Width-1:0]           wr_data1,
  input  logic                       rd,
  output logic [Width-1:0]           head,
  output logic [$clog2(Depth):0]     count
);
  localparam int unsigned AW   = $clog2(Depth);
  localparam int unsigned CntW = AW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;

  // Caller never requests more than two writes or writes beyond free space.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '{default: '0};
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr_cnt != 2'd0) mem_q[wptr_q] <= wr_data0;
      if (wr_cnt == 2'd2) mem_q[wptr_q + AW'(1)] <= wr_data1;
      wptr_q  <= wptr_q + AW'(wr_cnt);
      if (rd) rptr_q <= rptr_q + AW'(1);
      count_q <= count_q + CntW'(wr_cnt) - CntW'(rd);
    end
  end

  assign head  = (count_q != '0) ? mem_q[rptr_q] : '0;
  assign count = count_q;
endmodule

// File: rtl/mq_byte_out.sv
// MQ byte-output stage: pending byte B, carry propagation, flush tail and stuffing checks.
module mq_byte_out import mq_pkg::*; #(
  parameter int unsigned FIFO_DEPTH = DefFifoDepth,
  parameter int unsigned CNT_W      = DefCntW
) (
  input logic          clk,
  input logic          rst_n,
  mq_byte_out_if.slave bus
);
  localparam int unsigned CntFifoW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]          b_q, b_d, tail_q, tail_d;
  logic                dummy_q, dummy_d, flushed_q, flushed_d;
  logic                err_q, err_d, tail_vld_q, tail_vld_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                cnt_clr;
  logic [1:0]          wr_cnt;
  logic [7:0]          wr_data0, wr_data1, head;
  logic                rd, fifo_empty, in_ready;
  logic [CntFifoW-1:0] fifo_count;

  assign fifo_empty = (fifo_count == '0);
  // A held-over flush byte blocks new bundles until it has been written.
  assign in_ready   = !tail_vld_q && (int'(fifo_count) + 2 <= int'(FIFO_DEPTH));
  assign rd         = !fifo_empty && bus.byte_ready;

  always_comb begin
    logic [7:0] b, n;
    logic       dmy;
    logic [7:0] push [3];
    logic [1:0] np, nev;
    b          = b_q;
    dmy        = dummy_q;
    n          = '0;
    push       = '{default: '0};
    np         = 2'd0;
    nev        = 2'd0;
    flushed_d  = flushed_q;
    err_d      = err_q;
    tail_d     = tail_q;
    tail_vld_d = tail_vld_q;
    cnt_clr    = 1'b0;

    if (in_ready) begin
      if (bus.rst_BO) begin
        b         = '0;
        dmy       = 1'b1;
        flushed_d = 1'b0;
        err_d     = 1'b0;
        cnt_clr   = 1'b1;
      end else if (flushed_q) begin
        if (bus.Renor != 2'd0 || bus.AddB) err_d = 1'b1;
      end else begin
        if (bus.Renor == 2'd3) err_d = 1'b1;
        nev = (bus.Renor == 2'd3) ? 2'd2 : bus.Renor;
        if (bus.AddB) begin
          if (b == MARKER) err_d = 1'b1;
          b = b + 8'd1;
        end
        for (int k = 0; k < 2; k++) begin
          if (k < int'(nev)) begin
            n = slice_byte(bus.CShift8CT, k);
            if (bus.Carry[k]) begin
              if (b == MARKER) err_d = 1'b1;
              b = b + 8'd1;
            end
            if (!dmy) begin
              push[np] = b;
              np       = np + 2'd1;
              if (b == MARKER && n[7]) err_d = 1'b1;
            end
            b   = n;
            dmy = 1'b0;
          end
        end
        if (bus.flush_BO) begin
          if (!dmy && b != MARKER) begin
            push[np] = b;
            np       = np + 2'd1;
          end
          flushed_d = 1'b1;
        end
      end
    end
    b_d     = b;
    dummy_d = dmy;

    wr_data0 = push[0];
    wr_data1 = push[1];
    wr_cnt   = 2'd0;
    if (tail_vld_q) begin
      if (int'(fifo_count) < int'(FIFO_DEPTH)) begin
        wr_cnt     = 2'd1;
        wr_data0   = tail_q;
        tail_vld_d = 1'b0;
      end
    end else if (np == 2'd3) begin
      // Two events plus the flush byte: the third push is written next cycle.
      wr_cnt     = 2'd2;
      tail_d     = push[2];
      tail_vld_d = 1'b1;
    end else begin
      wr_cnt = np;
    end
  end

  always_comb begin
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt_q} + (CNT_W+1)'(wr_cnt);
    if (cnt_clr)       cnt_d = '0;
    else if (sum[CNT_W]) cnt_d = '1;
    else               cnt_d = sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_q        <= '0;
      dummy_q    <= 1'b1;
      flushed_q  <= 1'b0;
      err_q      <= 1'b0;
      tail_q     <= '0;
      tail_vld_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      b_q        <= b_d;
      dummy_q    <= dummy_d;
      flushed_q  <= flushed_d;
      err_q      <= err_d;
      tail_q     <= tail_d;
      tail_vld_q <= tail_vld_d;
      cnt_q      <= cnt_d;
    end
  end

  mq_bo_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (8)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_cnt   (wr_cnt),
    .wr_data0 (wr_data0),
    .wr_data1 (wr_data1),
    .rd       (rd),
    .head     (head),
    .count    (fifo_count)
  );

  assign bus.in_ready   = in_ready;
  assign bus.byte_data  = head;
  assign bus.byte_valid = !fifo_empty;
  assign bus.byte_count = cnt_q;
  assign bus.flush_done = flushed_q && fifo_empty && !tail_vld_q;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_mq_byte_out.sv
// Scoreboard bench for mq_byte_out: reference model queues expected bytes, monitor pops them.
module tb_mq_byte_out;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mq_byte_out_if #(.CNT_W(16)) bus ();

  mq_byte_out #(
    .FIFO_DEPTH (4),
    .CNT_W      (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [7:0]  exp_q [$];
  logic [7:0]  last_pop;
  logic [7:0]  prev_pop;
  int unsigned pops = 0;
  int unsigned ready_mode = 1;

  // Reference model state
  logic [7:0]  m_b;
  logic        m_dummy, m_flushed, m_err;
  int unsigned m_cnt;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_b = 8'h00; m_dummy = 1'b1; m_flushed = 1'b0; m_err = 1'b0; m_cnt = 0;
  endtask

  task automatic model_push(input logic [7:0] v);
    exp_q.push_back(v);
    if (m_cnt < 32'hFFFF) m_cnt++;
  endtask

  task automatic model_inc();
    if (m_b == 8'hFF) m_err = 1'b1;
    m_b = m_b + 8'd1;
  endtask

  task automatic model_apply(input logic addb, input logic [1:0] carry, input logic [1:0] renor,
                             input logic [7:0] n0, input logic [7:0] n1,
                             input logic flush, input logic rstbo);
    int unsigned ne;
    logic [7:0] n;
    if (rstbo) begin
      model_reset();
      return;
    end
    if (m_flushed) begin
      if (renor != 2'd0 || addb) m_err = 1'b1;
      return;
    end
    if (renor == 2'd3) m_err = 1'b1;
    ne = (renor == 2'd3) ? 2 : int'(renor);
    if (addb) model_inc();
    for (int k = 0; k < int'(ne); k++) begin
      n = (k == 0) ? n0 : n1;
      if (carry[k]) model_inc();
      if (!m_dummy) begin
        model_push(m_b);
        if (m_b == 8'hFF && n[7]) m_err = 1'b1;
      end
      m_b = n;
      m_dummy = 1'b0;
    end
    if (flush) begin
      if (!m_dummy && m_b != 8'hFF) model_push(m_b);
      m_flushed = 1'b1;
    end
  endtask

  task automatic idle_inputs();
    bus.AddB = 1'b0; bus.Carry = 2'b00; bus.Renor = 2'd0;
    bus.flush_BO = 1'b0; bus.rst_BO = 1'b0; bus.CShift8CT = '0;
  endtask

  // Drive one bundle; wait for in_ready; update the model at the sampling edge.
  task automatic send(input logic addb, input logic [1:0] carry, input logic [1:0] renor,
                      input logic [7:0] n0, input logic [7:0] n1,
                      input logic flush, input logic rstbo);
    int unsigned guard;
    @(negedge clk);
    bus.AddB = addb; bus.Carry = carry; bus.Renor = renor;
    bus.flush_BO = flush; bus.rst_BO = rstbo;
    bus.CShift8CT = {n1, 14'($urandom), n0, 14'($urandom)};
    guard = 0;
    while (!bus.in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.in_ready) begin
      check_eq("in_ready_timeout", {31'b0, bus.in_ready}, 1);
      idle_inputs();
      return;
    end
    model_apply(addb, carry, renor, n0, n1, flush, rstbo);
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic load(input logic [7:0] n);
    send(1'b0, 2'b00, 2'd1, n, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic restart();
    send(1'b0, 2'b00, 2'd0, 8'h00, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic drain();
    int unsigned guard;
    guard = 0;
    do begin
      @(negedge clk);
      #1;
      guard++;
    end while ((exp_q.size() != 0 || bus.byte_valid) && guard < 500);
    check_eq("drain_done", {31'b0, bus.byte_valid}, 0);
  endtask

  task automatic set_ready(input int unsigned mode);
    ready_mode = mode;
    @(posedge clk);
    #3;
  endtask

  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       bus.byte_ready = 1'b0;
      1:       bus.byte_ready = 1'b1;
      default: bus.byte_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: a handshake seen here completes at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && bus.byte_valid && bus.byte_ready) begin
      check_eq("sb_nonempty_at_pop", {31'b0, exp_q.size() != 0}, 1);
      if (exp_q.size() != 0) check_eq("pop_data", {24'b0, bus.byte_data}, {24'b0, exp_q.pop_front()});
      prev_pop = last_pop;
      last_pop = bus.byte_data;
      pops++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    bus.byte_ready = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("rst_in_ready", {31'b0, bus.in_ready}, 1);
    check_eq("rst_valid", {31'b0, bus.byte_valid}, 0);
    check_eq("rst_data", {24'b0, bus.byte_data}, 0);
    check_eq("rst_flush_done", {31'b0, bus.flush_done}, 0);
    check_eq("rst_err", {31'b0, bus.err}, 0);
    check_eq("rst_count", {16'b0, bus.byte_count}, 0);
    rst_n = 1'b1;

    // Async reset mid-stream, then restart behaviour
    set_ready(0);
    load(8'hAA);
    load(8'hBB);
    load(8'hCC);
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    model_reset();
    @(negedge clk);
    check_eq("midrst_valid", {31'b0, bus.byte_valid}, 0);
    rst_n = 1'b1;
    set_ready(1);
    load(8'h12);
    check_eq("dummy_no_push", {16'b0, bus.byte_count}, 0);
    load(8'h34);
    check_eq("first_count", {16'b0, bus.byte_count}, 1);
    drain();
    check_eq("first_byte", {24'b0, last_pop}, 32'h12);

    // Carry propagation
    load(8'h7E);
    send(1'b0, 2'b01, 2'd1, 8'h40, 8'h00, 1'b0, 1'b0);
    drain();
    check_eq("carry_byte", {24'b0, last_pop}, 32'h7F);
    load(8'h7E);
    send(1'b1, 2'b01, 2'd1, 8'h20, 8'h00, 1'b0, 1'b0);
    drain();
    check_eq("addb_carry_byte", {24'b0, last_pop}, 32'h80);

    // Dual event
    load(8'h10);
    send(1'b0, 2'b10, 2'd2, 8'h20, 8'h30, 1'b0, 1'b0);
    drain();
    check_eq("dual_first", {24'b0, prev_pop}, 32'h10);
    check_eq("dual_second", {24'b0, last_pop}, 32'h21);

    // Stall with sink held off
    set_ready(0);
    send(1'b0, 2'b00, 2'd2, 8'h01, 8'h02, 1'b0, 1'b0);
    check_eq("stall_half_ready", {31'b0, bus.in_ready}, 1);
    send(1'b0, 2'b00, 2'd2, 8'h03, 8'h04, 1'b0, 1'b0);
    check_eq("stall_full_ready", {31'b0, bus.in_ready}, 0);
    check_eq("stall_head", {24'b0, bus.byte_data}, 32'h30);
    check_eq("stall_count", {16'b0, bus.byte_count}, m_cnt);
    set_ready(1);
    drain();
    check_eq("pre_stuff_err", {31'b0, bus.err}, 0);

    // Marker stuffing
    load(8'hFF);
    load(8'h80);
    check_eq("stuff_err", {31'b0, bus.err}, 1);
    restart();
    check_eq("restart_err_clr", {31'b0, bus.err}, 0);
    load(8'hFF);
    load(8'h7F);
    check_eq("stuff_ok", {31'b0, bus.err}, 0);
    drain();
    check_eq("stuff_ok_byte", {24'b0, last_pop}, 32'hFF);

    // Flush with B = 0xFF
    load(8'hFF);
    drain();
    send(1'b0, 2'b00, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0);
    check_eq("flushff_done", {31'b0, bus.flush_done}, 1);
    check_eq("flushff_valid", {31'b0, bus.byte_valid}, 0);
    check_eq("flushff_count", {16'b0, bus.byte_count}, m_cnt);
    load(8'h11);
    check_eq("post_flush_err", {31'b0, bus.err}, 1);

    // Flush of 0x55 with sink stalled
    restart();
    load(8'h55);
    set_ready(0);
    send(1'b0, 2'b00, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0);
    check_eq("flush55_head", {24'b0, bus.byte_data}, 32'h55);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("flush55_wait", {31'b0, bus.flush_done}, 0);
    end
    set_ready(1);
    begin
      int unsigned guard;
      guard = 0;
      while (exp_q.size() != 0 && guard < 50) begin
        @(negedge clk);
        #1;
        guard++;
      end
    end
    check_eq("flush55_pending", {31'b0, bus.flush_done}, 0);
    @(posedge clk);
    #1;
    check_eq("flush55_done", {31'b0, bus.flush_done}, 1);

    // Two events plus flush byte in one bundle
    restart();
    load(8'h01);
    send(1'b0, 2'b00, 2'd2, 8'h02, 8'h03, 1'b1, 1'b0);
    drain();
    check_eq("tail_last", {24'b0, last_pop}, 32'h03);
    check_eq("tail_count", {16'b0, bus.byte_count}, 3);
    check_eq("tail_done", {31'b0, bus.flush_done}, 1);

    // Random back-pressure
    restart();
    pops = 0;
    set_ready(2);
    for (int i = 0; i < 1000; i++) begin
      send(1'(($urandom_range(0, 7) == 0)), 2'($urandom), 2'($urandom_range(0, 2)),
           8'($urandom), 8'($urandom), 1'b0, 1'b0);
    end
    send(1'b0, 2'b00, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0);
    set_ready(1);
    drain();
    check_eq("rand_count_pops", {16'b0, bus.byte_count}, pops);
    check_eq("rand_count_model", {16'b0, bus.byte_count}, m_cnt);
    check_eq("rand_err", {31'b0, bus.err}, {31'b0, m_err});
    check_eq("rand_flush_done", {31'b0, bus.flush_done}, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
